// File: rtl/merge_feeder.sv
// merge_feeder
//   Front end of the hardware merge sorter. Each cycle it compares the
//   record-0 keys of the head batches of inputs A and B, pops the smaller
//   one (ties go to A) and registers that batch onto dot with doten. When
//   one run ends, the other input's remainder is drained. Optionally, a
//   max-key flush batch is then emitted to push held records out of the
//   merge network.
//
//   Build option: define FEEDER_FLUSH_EN to build the FLUSH state. Each
//   run then ends with an all-ones-key batch that carries run_done.
//   Without it, run_done rides on the last drained batch.
//
// Parameters
//   E_LOG  log2 of records per batch (1..5)
//   DATW   record width in bits
//   KEYW   key width; key = record[KEYW-1:0]
//
// Ports
//   CLK, RST         clock, synchronous active-high reset
//   a_din/b_din      head batch of input A/B
//   a_emp/b_emp      input FIFO empty
//   a_last/b_last    head batch is the last of its run
//   a_deq/b_deq      combinational pop strobes (never both high; 0 in reset)
//   stall            downstream hold: no pop, no output
//   dot, doten       registered selected batch and its valid
//   run_done         registered pulse on the final batch of a merged run
//   run_cnt          completed-run counter (wraps)
module merge_feeder #(
    parameter int E_LOG = 2,
    parameter int DATW  = 64,
    parameter int KEYW  = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [(DATW<<E_LOG)-1:0] a_din,
    input  logic                     a_emp,
    input  logic                     a_last,
    output logic                     a_deq,
    input  logic [(DATW<<E_LOG)-1:0] b_din,
    input  logic                     b_emp,
    input  logic                     b_last,
    output logic                     b_deq,
    input  logic                     stall,
    output logic [(DATW<<E_LOG)-1:0] dot,
    output logic                     doten,
    output logic                     run_done,
    output logic [15:0]              run_cnt
);

    localparam int BW = DATW << E_LOG;

`ifdef FEEDER_FLUSH_EN
    // One record with an all-ones key and zero payload; works for KEYW == DATW too.
    localparam logic [DATW-1:0] FLUSH_REC   = (DATW'(1) << KEYW) - DATW'(1);
    localparam logic [BW-1:0]   FLUSH_BATCH = {(1 << E_LOG){FLUSH_REC}};
`endif

    typedef enum logic [1:0] {
        MERGE,
        DRAIN_A,
        DRAIN_B
`ifdef FEEDER_FLUSH_EN
        , FLUSH
`endif
    } state_t;

    state_t state, state_next;

    logic          a_wins;
    logic          pop_a, pop_b;
    logic          fire;
    logic          run_end;
    logic [BW-1:0] dot_next;

    assign a_wins = (a_din[KEYW-1:0] <= b_din[KEYW-1:0]);

    always_comb begin
        state_next = state;
        pop_a      = 1'b0;
        pop_b      = 1'b0;
        fire       = 1'b0;
        run_end    = 1'b0;
        dot_next   = b_din;
        case (state)
            MERGE: begin
                if (!a_emp && !b_emp && !stall) begin
                    fire = 1'b1;
                    if (a_wins) begin
                        pop_a    = 1'b1;
                        dot_next = a_din;
                        if (a_last) state_next = DRAIN_B;
                    end else begin
                        pop_b = 1'b1;
                        if (b_last) state_next = DRAIN_A;
                    end
                end
            end
            DRAIN_A: begin
                if (!a_emp && !stall) begin
                    fire     = 1'b1;
                    pop_a    = 1'b1;
                    dot_next = a_din;
                    if (a_last) begin
`ifdef FEEDER_FLUSH_EN
                        state_next = FLUSH;
`else
                        state_next = MERGE;
                        run_end    = 1'b1;
`endif
                    end
                end
            end
            DRAIN_B: begin
                if (!b_emp && !stall) begin
                    fire  = 1'b1;
                    pop_b = 1'b1;
                    if (b_last) begin
`ifdef FEEDER_FLUSH_EN
                        state_next = FLUSH;
`else
                        state_next = MERGE;
                        run_end    = 1'b1;
`endif
                    end
                end
            end
`ifdef FEEDER_FLUSH_EN
            FLUSH: begin
                if (!stall) begin
                    fire       = 1'b1;
                    run_end    = 1'b1;
                    dot_next   = FLUSH_BATCH;
                    state_next = MERGE;
                end
            end
`endif
            default: state_next = MERGE;
        endcase
    end

    assign a_deq = pop_a & ~RST;
    assign b_deq = pop_b & ~RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= MERGE;
            dot      <= '0;
            doten    <= 1'b0;
            run_done <= 1'b0;
            run_cnt  <= '0;
        end else begin
            state    <= state_next;
            doten    <= fire;
            run_done <= run_end;
            if (fire)    dot     <= dot_next;
            if (run_end) run_cnt <= run_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_merge_feeder.sv
module tb_merge_feeder;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [255:0] a_din = '0, b_din = '0;
    logic         a_emp = 1'b1, b_emp = 1'b1, a_last = 1'b0, b_last = 1'b0;
    logic         stall = 1'b0;
    logic         a_deq, b_deq, doten, run_done;
    logic [255:0] dot;
    logic [15:0]  run_cnt;

`ifdef FEEDER_FLUSH_EN
    localparam bit FLUSH_ON = 1'b1;
`else
    localparam bit FLUSH_ON = 1'b0;
`endif

    merge_feeder #(.E_LOG(2), .DATW(64), .KEYW(32)) dut (
        .CLK(CLK), .RST(RST),
        .a_din(a_din), .a_emp(a_emp), .a_last(a_last), .a_deq(a_deq),
        .b_din(b_din), .b_emp(b_emp), .b_last(b_last), .b_deq(b_deq),
        .stall(stall), .dot(dot), .doten(doten),
        .run_done(run_done), .run_cnt(run_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [255:0] data;
        bit           done;
    } exp_t;

    typedef struct {
        int unsigned         na, nb, ne;
        logic [0:3][31:0]    ak, bk;
        logic [0:7][31:0]    ek;
        logic [0:7][7:0]     es;   // 8'hA / 8'hB source, 8'hF flush batch
    } vec_t;

    logic [31:0] qa_k[$], qb_k[$];
    bit          qa_l[$], qb_l[$];
    exp_t        sb[$];
    int          n_vec = 0, n_err = 0, exp_runs = 0;
    vec_t        vt[6];

    function automatic logic [255:0] mk_batch(logic [31:0] k, logic [7:0] tag);
        logic [255:0] b;
        for (int unsigned r = 0; r < 4; r++)
            b[r*64 +: 64] = {tag, 8'(r), 16'hC0DE, (r == 0) ? k : (k ^ (32'h1111_1111 * r))};
        return b;
    endfunction

    function automatic logic [255:0] flush_batch();
        logic [255:0] b;
        for (int unsigned r = 0; r < 4; r++) b[r*64 +: 64] = {32'h0, 32'hFFFF_FFFF};
        return b;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] k, input logic [7:0] tag, input bit done);
        exp_t e;
        e.data = (tag == 8'hF) ? flush_batch() : mk_batch(k, tag);
        e.done = done;
        sb.push_back(e);
    endtask

    // One clock: drive at negedge, check pops before posedge, check outputs #1 after.
    task automatic step(input bit st, input bit ha, input bit hb, output bit pa, output bit pb);
        bit   was_rst;
        exp_t e;
        stall   = st;
        was_rst = RST;
        a_emp   = ha || (qa_k.size() == 0);
        b_emp   = hb || (qb_k.size() == 0);
        a_din   = (qa_k.size() != 0) ? mk_batch(qa_k[0], 8'hA) : '0;
        a_last  = (qa_k.size() != 0) ? qa_l[0] : 1'b0;
        b_din   = (qb_k.size() != 0) ? mk_batch(qb_k[0], 8'hB) : '0;
        b_last  = (qb_k.size() != 0) ? qb_l[0] : 1'b0;
        #2;
        pa = a_deq;
        pb = b_deq;
        chk("deq_both", 256'(a_deq & b_deq), 0);
        if (a_emp) chk("a_deq_empty", 256'(a_deq), 0);
        if (b_emp) chk("b_deq_empty", 256'(b_deq), 0);
        if (st || was_rst) begin
            chk("a_deq_held", 256'(a_deq), 0);
            chk("b_deq_held", 256'(b_deq), 0);
        end
        @(posedge CLK);
        if (pa && qa_k.size() != 0) begin void'(qa_k.pop_front()); void'(qa_l.pop_front()); end
        if (pb && qb_k.size() != 0) begin void'(qb_k.pop_front()); void'(qb_l.pop_front()); end
        #1;
        if (was_rst) begin
            chk("rst_doten", 256'(doten), 0);
            chk("rst_dot", dot, 0);
            chk("rst_run_done", 256'(run_done), 0);
            chk("rst_run_cnt", 256'(run_cnt), 0);
        end else begin
            if (st) chk("doten_after_stall", 256'(doten), 0);
            if (doten) begin
                if (sb.size() == 0) chk("unexpected_doten", 256'(doten), 0);
                else begin
                    e = sb.pop_front();
                    chk("dot", dot, e.data);
                    chk("run_done", 256'(run_done), 256'(e.done));
                    if (e.done) begin
                        exp_runs++;
                        chk("run_cnt_at_done", 256'(run_cnt), 256'(16'(exp_runs)));
                    end
                end
            end else chk("run_done_idle", 256'(run_done), 0);
        end
        @(negedge CLK);
    endtask

    task automatic load_vec(input int unsigned idx);
        for (int unsigned i = 0; i < vt[idx].na; i++) begin
            qa_k.push_back(vt[idx].ak[i]); qa_l.push_back(i == vt[idx].na - 1);
        end
        for (int unsigned i = 0; i < vt[idx].nb; i++) begin
            qb_k.push_back(vt[idx].bk[i]); qb_l.push_back(i == vt[idx].nb - 1);
        end
        for (int unsigned i = 0; i < vt[idx].ne; i++) begin
            if (vt[idx].es[i] == 8'hF && !FLUSH_ON) continue;
            push_exp(vt[idx].ek[i], vt[idx].es[i],
                     FLUSH_ON ? (i == vt[idx].ne - 1) : (i == vt[idx].ne - 2));
        end
    endtask

    task automatic drain_sb(input bit rnd, input bit fixed_stall);
        bit pa, pb, st;
        for (int c = 0; c < 400 && sb.size() != 0; c++) begin
            st = fixed_stall ? (c >= 2 && c <= 4) : (rnd && $urandom_range(0, 3) == 0);
            step(st, rnd && $urandom_range(0, 4) == 0, rnd && $urandom_range(0, 4) == 0, pa, pb);
        end
        if (sb.size() != 0) chk("timeout_outputs_left", 256'(sb.size()), 0);
        for (int c = 0; c < 2; c++) step(1'b0, 1'b0, 1'b0, pa, pb);
        chk("run_cnt_after_run", 256'(run_cnt), 256'(16'(exp_runs)));
        qa_k.delete(); qa_l.delete(); qb_k.delete(); qb_l.delete(); sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pa, pb;
        vt[0] = '{na:3, nb:3, ne:7, ak:{32'd1, 32'd5, 32'd9, 32'd0}, bk:{32'd3, 32'd7, 32'd11, 32'd0},
                  ek:{32'd1, 32'd3, 32'd5, 32'd7, 32'd9, 32'd11, 32'd0, 32'd0},
                  es:{8'hA, 8'hB, 8'hA, 8'hB, 8'hA, 8'hB, 8'hF, 8'h0}};
        vt[1] = '{na:2, nb:2, ne:5, ak:{32'd4, 32'd8, 32'd0, 32'd0}, bk:{32'd4, 32'd6, 32'd0, 32'd0},
                  ek:{32'd4, 32'd4, 32'd6, 32'd8, 32'd0, 32'd0, 32'd0, 32'd0},
                  es:{8'hA, 8'hB, 8'hB, 8'hA, 8'hF, 8'h0, 8'h0, 8'h0}};
        vt[2] = '{na:1, nb:1, ne:3, ak:{32'd2, 32'd0, 32'd0, 32'd0}, bk:{32'd3, 32'd0, 32'd0, 32'd0},
                  ek:{32'd2, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                  es:{8'hA, 8'hB, 8'hF, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}};
        vt[3] = '{na:1, nb:3, ne:5, ak:{32'd1, 32'd0, 32'd0, 32'd0}, bk:{32'd2, 32'd3, 32'd4, 32'd0},
                  ek:{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0},
                  es:{8'hA, 8'hB, 8'hB, 8'hB, 8'hF, 8'h0, 8'h0, 8'h0}};
        vt[4] = '{na:2, nb:1, ne:4, ak:{32'd10, 32'd20, 32'd0, 32'd0}, bk:{32'd5, 32'd0, 32'd0, 32'd0},
                  ek:{32'd5, 32'd10, 32'd20, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                  es:{8'hB, 8'hA, 8'hA, 8'hF, 8'h0, 8'h0, 8'h0, 8'h0}};
        vt[5] = '{na:2, nb:1, ne:4, ak:{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0}, bk:{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0},
                  ek:{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                  es:{8'hA, 8'hA, 8'hB, 8'hF, 8'h0, 8'h0, 8'h0, 8'h0}};

        // Reset with both inputs non-empty
        RST = 1'b1;
        qa_k.push_back(32'd1); qa_l.push_back(1'b0);
        qb_k.push_back(32'd2); qb_l.push_back(1'b0);
        @(negedge CLK);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, pa, pb);
        RST = 1'b0;
        qa_k.delete(); qa_l.delete(); qb_k.delete(); qb_l.delete();

        // Table: vector 0 with a fixed 3-cycle stall, then all with random stall/empty gaps
        load_vec(0);
        drain_sb(1'b0, 1'b1);
        for (int unsigned v = 0; v < 6; v++) begin
            load_vec(v);
            drain_sb(1'b1, 1'b0);
        end

        // B empty in MERGE: nothing moves; then A's last pops and B drains back to back
        qa_k.push_back(32'd1); qa_l.push_back(1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, pa, pb);
            chk("no_pop_b_empty", 256'({pa, pb}), 0);
        end
        qb_k.push_back(32'd5); qb_l.push_back(1'b0);
        qb_k.push_back(32'd6); qb_l.push_back(1'b0);
        qb_k.push_back(32'd7); qb_l.push_back(1'b1);
        push_exp(32'd1, 8'hA, 1'b0);
        push_exp(32'd5, 8'hB, 1'b0);
        push_exp(32'd6, 8'hB, 1'b0);
        push_exp(32'd7, 8'hB, !FLUSH_ON);
        if (FLUSH_ON) push_exp(32'd0, 8'hF, 1'b1);
        step(1'b0, 1'b0, 1'b0, pa, pb);
        chk("a_last_pop", 256'(pa), 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, pa, pb);
            chk("drain_b_pop", 256'(pb), 1);
        end
        drain_sb(1'b0, 1'b0);

        // Reset mid-run discards the run
        qa_k.push_back(32'd1); qa_l.push_back(1'b0);
        qa_k.push_back(32'd2); qa_l.push_back(1'b1);
        qb_k.push_back(32'd3); qb_l.push_back(1'b1);
        push_exp(32'd1, 8'hA, 1'b0);
        step(1'b0, 1'b0, 1'b0, pa, pb);
        RST = 1'b1;
        step(1'b0, 1'b0, 1'b0, pa, pb);
        RST = 1'b0;
        exp_runs = 0;
        qa_k.delete(); qa_l.delete(); qb_k.delete(); qb_l.delete();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, pa, pb);
        load_vec(0);
        drain_sb(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/merge_feeder.md
# merge_feeder

Upstream front end of the hardware merge sorter. Takes two sorted runs arriving as E-record batches from two input FIFOs, picks the batch whose leading key is smaller each cycle, and presents the selected batch with a valid strobe to the merge network. It also tracks run boundaries: it drains the surviving input after one run ends and emits a max-key flush batch so the network pushes its held records out. It replaces the ad-hoc comparator, mux and dequeue glue around the merge network.

## Interface
- E_LOG, 2, log2 of records per batch (E = 1<<E_LOG), range 1–5
- DATW, 64, record width in bits
- KEYW, 32, key width; key = record bits [KEYW-1:0]
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- a_din  in  DATW<<E_LOG  head batch of input A
- a_emp  in  1  input A FIFO empty
- a_last  in  1  head batch of A is the last batch of its run
- a_deq  out  1  pop input A (combinational)
- b_din, b_emp, b_last, b_deq: same as the A ports, for input B
- stall  in  1  downstream hold; no pop and no output while high
- dot  out  DATW<<E_LOG  selected batch to the merge network
- doten  out  1  dot valid
- run_done  out  1  one-cycle pulse marking the final output batch of a merged run
- run_cnt  out  16  completed runs, wraps 16'hFFFF→0

## Operation
- Comparison uses the key of record 0 of each head batch: kA = a_din[KEYW-1:0], kB = b_din[KEYW-1:0]. A wins when kA <= kB, so ties go to A.
- States: MERGE, DRAIN_A, DRAIN_B, FLUSH. Reset state is MERGE.
- MERGE:
  - Fires when !a_emp && !b_emp && !stall.
  - Pops the winner only and outputs its batch.
  - If the winner's last flag is set, go to DRAIN of the other input (A won → DRAIN_B; B won → DRAIN_A).
  - If either input is empty: no pop, no output, hold state.
- DRAIN_X:
  - Fires when X is not empty and !stall.
  - Pops X and outputs its batch.
  - If X's last flag is set, go to FLUSH.
  - The emptiness of the other input is ignored.
- FLUSH:
  - Fires when !stall.
  - Outputs the flush batch: every record has key all-ones and all non-key bits zero.
  - Pops nothing, pulses run_done, increments run_cnt, returns to MERGE.
- Both heads last in the same MERGE cycle: winner pops and the state moves to drain the other input. That drain pops the other input's single last batch next, then FLUSH.
- a_deq and b_deq are never high in the same cycle. Both are forced to 0 while RST is high.
- Reset values: dot=0, doten=0, run_done=0, run_cnt=0, state=MERGE.
- Asserting RST mid-run discards the run: no flush is emitted and no run_done pulses.

## Timing
- Pops are combinational in the same cycle as the decision.
- dot, doten and run_done are registered: a batch popped in cycle t appears with doten=1 in cycle t+1.
- Throughput is one batch per cycle while not stalled.
- stall high in cycle t: no pop in t, doten=0 in t+1, state and run_cnt held. Effect is immediate; there is no skid.
- doten=0 in every cycle without a fire. dot holds its last value when doten=0.
- run_cnt updates in the same cycle run_done is high.

## Configuration
- FEEDER_FLUSH_EN defined:
  - FLUSH state present, behaving as described above.
  - Each run ends with one extra all-ones-key batch, which carries run_done.
- FEEDER_FLUSH_EN undefined:
  - FLUSH is not built.
  - DRAIN_X popping its last batch returns directly to MERGE.
  - run_done and the run_cnt increment coincide with that last drained batch.
  - No flush batch is ever emitted.

## Test plan
- Reset: RST held 4 cycles with both inputs non-empty → a_deq=b_deq=0 throughout, doten=0, dot=0, run_cnt=0.
- Interleave (E_LOG=2, flush on): A heads 1,5,9 (9 last), B heads 3,7,11 (11 last) → doten batches with record-0 keys 1,3,5,7,9,11, then a batch of keys 0xFFFFFFFF with run_done=1; run_cnt=1.
- Tie: A head key 4, B head key 4 → a_deq first; A's batch on dot next cycle, then B's.
- Stall: stall high for 3 cycles mid-run → no pops and doten=0 for 3 cycles; output key order unchanged afterwards.
- Empty handling: B empty in MERGE with A non-empty → no pop, no output; after A's last batch, DRAIN_B pops B's remaining batches one per cycle regardless of a_emp.
- Flush off (FEEDER_FLUSH_EN undefined), same stimulus as the interleave case → exactly 6 batches; run_done=1 with the key-11 batch; run_cnt=1; no all-ones batch.
